postadder_multi: RTL and testbench

Parametrised successor of the three-accumulator post-adder. It provides N_CH independent accumulator channels, each with a DEPTH-entry register file holding values in redundant limb form with signed carry headroom. When an entry's carry headroom is exhausted, the block normalises that entry automatically and stalls the input handshake while it does so. A registered read port returns the exact signed integer value of any entry. The block sits after the multiplier datapath and feeds the final reduction stage.

---
 rtl/postadder_multi.sv | 209 ++++++++++++++++++++
 tb/tb_postadder_multi.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/postadder_multi.sv
// Multi-channel redundant-limb accumulator bank with automatic carry normalisation
// and a registered signed read port.
module postadder_multi #(
  parameter int N_CH    = 3,
  parameter int DEPTH   = 4,
  parameter int W       = 256,
  parameter int ADD_DIV = 4,
  parameter int CARRY_W = 8,
  parameter int NORM_TH = 2**(CARRY_W-1)-1,
  parameter logic [W-1:0] MOD = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int RW  = W + CARRY_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      din,
  input  logic [3*N_CH-1:0] mode,
  input  logic [AW*N_CH-1:0] addr,
  input  logic              rd_en,
  input  logic [CHW-1:0]    rd_ch,
  input  logic [AW-1:0]     rd_addr,
  output logic              rd_valid,
  output logic [RW-1:0]     rd_data
);

  localparam int LIMB_W = W / ADD_DIV;
  localparam int FW     = LIMB_W + CARRY_W;
  localparam int SW     = (ADD_DIV > 2) ? $clog2(ADD_DIV-1) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_NORM = 1'b1} state_t;

  state_t               r_state;
  logic [SW-1:0]        r_step;
  logic                 r_in_ready;
  logic                 r_rd_valid;
  logic [RW-1:0]        r_rd_data;

  logic signed [FW-1:0] r_limb [N_CH][DEPTH][ADD_DIV];
  logic signed [FW-1:0] w_limb [N_CH][DEPTH][ADD_DIV];
  logic [CARRY_W-1:0]   r_cnt  [N_CH][DEPTH];
  logic [CARRY_W-1:0]   w_cnt  [N_CH][DEPTH];
  logic                 r_pend [N_CH][DEPTH];
  logic                 w_pend [N_CH][DEPTH];

  logic                 w_fire;
  logic                 w_go_norm;
  logic                 w_last_step;
  logic [AW-1:0]        w_a;
  logic [2:0]           w_m;
  logic signed [FW-1:0] w_d;
  logic signed [FW-1:0] w_mi;
  logic [RW-1:0]        w_rd_val;

  assign w_fire      = in_valid & (r_state == S_IDLE);
  assign w_last_step = (r_step == SW'(ADD_DIV-2));
  assign in_ready    = r_in_ready;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;

  // Next-state of the register file: limb-wise opcode updates, or one carry step per pending entry.
  always_comb begin
    w_limb    = r_limb;
    w_cnt     = r_cnt;
    w_pend    = r_pend;
    w_go_norm = 1'b0;
    w_a       = {AW{1'b0}};
    w_m       = 3'b000;
    w_d       = {FW{1'b0}};
    w_mi      = {FW{1'b0}};
    if (w_fire) begin
      for (int c = 0; c < N_CH; c++) begin
        w_a = addr[c*AW +: AW];
        w_m = mode[3*c +: 3];
        for (int i = 0; i < ADD_DIV; i++) begin
          w_d  = FW'(din[i*LIMB_W +: LIMB_W]);
          w_mi = FW'(MOD[i*LIMB_W +: LIMB_W]);
          case (w_m)
            3'b001:  w_limb[c][w_a][i] = w_d;
            3'b010:  w_limb[c][w_a][i] = r_limb[c][w_a][i] + w_d;
            3'b011:  w_limb[c][w_a][i] = w_d - r_limb[c][w_a][i];
            3'b100:  w_limb[c][w_a][i] = r_limb[c][w_a][i] - w_d;
            3'b101:  w_limb[c][w_a][i] = w_mi - r_limb[c][w_a][i];
            3'b110:  w_limb[c][w_a][i] = w_mi - w_d;
            3'b111:  w_limb[c][w_a][i] = {FW{1'b0}};
            default: w_limb[c][w_a][i] = r_limb[c][w_a][i];
          endcase
        end
        case (w_m)
          3'b001, 3'b110, 3'b111: w_cnt[c][w_a] = {CARRY_W{1'b0}};
          3'b010, 3'b011, 3'b100, 3'b101: begin
            w_cnt[c][w_a] = r_cnt[c][w_a] + 1'b1;
            if (w_cnt[c][w_a] == CARRY_W'(NORM_TH)) begin
              w_pend[c][w_a] = 1'b1;
              w_go_norm      = 1'b1;
            end else begin
              w_pend[c][w_a] = r_pend[c][w_a];
            end
          end
          default: w_cnt[c][w_a] = r_cnt[c][w_a];
        endcase
      end
    end else if (r_state == S_NORM) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (r_pend[c][e]) begin
            // Move limb k's signed overflow into limb k+1; the top limb keeps its carry.
            for (int k = 0; k < ADD_DIV-1; k++) begin
              if (r_step == SW'(k)) begin
                w_limb[c][e][k]   = {{CARRY_W{1'b0}}, r_limb[c][e][k][LIMB_W-1:0]};
                w_limb[c][e][k+1] = r_limb[c][e][k+1] + (r_limb[c][e][k] >>> LIMB_W);
              end else begin
                w_limb[c][e][k]   = w_limb[c][e][k];
              end
            end
            if (w_last_step) begin
              w_cnt[c][e]  = {CARRY_W{1'b0}};
              w_pend[c][e] = 1'b0;
            end else begin
              w_pend[c][e] = r_pend[c][e];
            end
          end else begin
            w_pend[c][e] = r_pend[c][e];
          end
        end
      end
    end else begin
      w_go_norm = 1'b0;
    end
  end

  // Register file, counts and pending flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int e = 0; e < DEPTH; e++) begin
          r_cnt[c][e]  <= {CARRY_W{1'b0}};
          r_pend[c][e] <= 1'b0;
          for (int i = 0; i < ADD_DIV; i++) begin
            r_limb[c][e][i] <= {FW{1'b0}};
          end
        end
      end
    end else begin
      r_limb <= w_limb;
      r_cnt  <= w_cnt;
      r_pend <= w_pend;
    end
  end

  // Control FSM: IDLE accepts operations, NORM walks the carry chain for pending entries.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_step     <= {SW{1'b0}};
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go_norm) begin
            r_state    <= S_NORM;
            r_step     <= {SW{1'b0}};
            r_in_ready <= 1'b0;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_NORM: begin
          if (w_last_step) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_step <= r_step + 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Collapse the selected entry's limbs into one signed integer.
  always_comb begin
    w_rd_val = {RW{1'b0}};
    for (int i = 0; i < ADD_DIV; i++) begin
      w_rd_val = w_rd_val + (RW'(r_limb[rd_ch][rd_addr][i]) << (LIMB_W*i));
    end
  end

  // Registered read port; data holds between requests.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= {RW{1'b0}};
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_val;
      end else begin
        r_rd_data <= r_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_postadder_multi.sv
// Bench for postadder_multi: integer-valued reference model per entry, directed
// cases plus randomized mixed operation/read traffic.
module tb_postadder_multi;

  localparam int N_CH    = 3;
  localparam int DEPTH   = 4;
  localparam int W       = 256;
  localparam int CARRY_W = 8;
  localparam int AW      = 2;
  localparam int RW      = W + CARRY_W;
  localparam int NORM_TH = 127;
  localparam logic [W-1:0] MODV = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [W-1:0]      din = '0;
  logic [3*N_CH-1:0] mode = '0;
  logic [AW*N_CH-1:0] addr = '0;
  logic              rd_en = 1'b0;
  logic [1:0]        rd_ch = '0;
  logic [AW-1:0]     rd_addr = '0;
  logic              rd_valid;
  logic [RW-1:0]     rd_data;

  postadder_multi dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .mode(mode), .addr(addr), .rd_en(rd_en), .rd_ch(rd_ch),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: each entry is just its integer value modulo 2^RW plus an op count.
  logic [RW-1:0] m_val [N_CH][DEPTH];
  int            m_cnt [N_CH][DEPTH];
  logic [RW-1:0] m_last_rd;

  task automatic check_val(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++)
      for (int e = 0; e < DEPTH; e++) begin
        m_val[c][e] = '0;
        m_cnt[c][e] = 0;
      end
    m_last_rd = '0;
  endtask

  task automatic model_apply(input logic [3*N_CH-1:0] md, input logic [AW*N_CH-1:0] ad,
                             input logic [W-1:0] d, output bit hit);
    logic [RW-1:0] dx;
    logic [RW-1:0] px;
    int a;
    dx  = RW'(d);
    px  = RW'(MODV);
    hit = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      a = int'(ad[c*AW +: AW]);
      case (md[3*c +: 3])
        3'd1: begin m_val[c][a] = dx;               m_cnt[c][a] = 0; end
        3'd2: begin m_val[c][a] = m_val[c][a] + dx; m_cnt[c][a]++;   end
        3'd3: begin m_val[c][a] = dx - m_val[c][a]; m_cnt[c][a]++;   end
        3'd4: begin m_val[c][a] = m_val[c][a] - dx; m_cnt[c][a]++;   end
        3'd5: begin m_val[c][a] = px - m_val[c][a]; m_cnt[c][a]++;   end
        3'd6: begin m_val[c][a] = px - dx;          m_cnt[c][a] = 0; end
        3'd7: begin m_val[c][a] = '0;               m_cnt[c][a] = 0; end
        default: ;
      endcase
      if (m_cnt[c][a] == NORM_TH) begin
        hit = 1'b1;
        m_cnt[c][a] = 0;
      end
    end
  endtask

  // One cycle of traffic starting and ending on a falling edge.
  task automatic step(input bit op, input logic [3*N_CH-1:0] md, input logic [AW*N_CH-1:0] ad,
                      input logic [W-1:0] d, input bit rd, input int rc, input int ra);
    logic [RW-1:0] exp_rd;
    int guard;
    bit hit;
    hit = 1'b0;
    if (op) begin
      guard = 0;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) check_val("ready_wait", RW'(in_ready), RW'(1));
    end
    in_valid = op; mode = md; addr = ad; din = d;
    rd_en = rd; rd_ch = 2'(rc); rd_addr = AW'(ra);
    exp_rd = m_val[rc][ra];
    @(posedge clk);
    if (op) model_apply(md, ad, d, hit);
    @(negedge clk);
    in_valid = 1'b0;
    rd_en = 1'b0;
    if (rd) begin
      check_val("rd_valid", RW'(rd_valid), RW'(1));
      check_val("rd_data", rd_data, exp_rd);
      m_last_rd = exp_rd;
    end else begin
      check_val("rd_idle", RW'(rd_valid), RW'(0));
      check_val("rd_hold", rd_data, m_last_rd);
    end
    if (hit) check_val("stall_start", RW'(in_ready), RW'(0));
  endtask

  task automatic single_op(input int c, input int a, input logic [2:0] m, input logic [W-1:0] d);
    logic [3*N_CH-1:0] md;
    logic [AW*N_CH-1:0] ad;
    md = '0;
    ad = '0;
    md[3*c +: 3]  = m;
    ad[c*AW +: AW] = AW'(a);
    step(1'b1, md, ad, d, 1'b0, 0, 0);
  endtask

  task automatic read_entry(input int c, input int a);
    step(1'b0, '0, '0, '0, 1'b1, c, a);
  endtask

  task automatic read_all();
    for (int c = 0; c < N_CH; c++)
      for (int e = 0; e < DEPTH; e++) read_entry(c, e);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [RW-1:0] big;
    logic [W-1:0]  rd_din;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_ready", RW'(in_ready), RW'(1));
    check_val("rst_rd_valid", RW'(rd_valid), RW'(0));
    check_val("rst_rd_data", rd_data, '0);
    rstn = 1'b1;
    @(negedge clk);
    read_all();

    single_op(0, 0, 3'b001, W'(5));
    single_op(0, 0, 3'b010, W'(7));
    read_entry(0, 0);
    check_val("sum12", rd_data, RW'(12));

    single_op(1, 2, 3'b111, W'(0));
    single_op(1, 2, 3'b100, W'(1));
    read_entry(1, 2);
    check_val("minus1", rd_data, {RW{1'b1}});
    read_entry(0, 0);
    read_entry(2, 2);

    single_op(0, 0, 3'b001, W'(1));
    single_op(0, 0, 3'b101, W'(0));
    read_entry(0, 0);
    check_val("p_minus1", rd_data, RW'(MODV) - RW'(1));
    single_op(0, 0, 3'b110, W'(0));
    read_entry(0, 0);
    check_val("p", rd_data, RW'(MODV));

    single_op(2, 3, 3'b001, W'(0));
    repeat (NORM_TH) single_op(2, 3, 3'b010, W'(64'hFFFF_FFFF_FFFF_FFFF));
    big = RW'(127) * RW'(64'hFFFF_FFFF_FFFF_FFFF);
    read_entry(2, 3);
    check_val("stall_1", RW'(in_ready), RW'(0));
    check_val("big_stall", rd_data, big);
    read_entry(2, 3);
    check_val("stall_2", RW'(in_ready), RW'(0));
    read_entry(2, 3);
    check_val("stall_end", RW'(in_ready), RW'(1));
    read_entry(2, 3);
    check_val("big_after", rd_data, big);
    check_val("limb0", RW'(dut.r_limb[2][3][0]), 264'hFFFF_FFFF_FFFF_FF81);
    check_val("limb1", RW'(dut.r_limb[2][3][1]), RW'(126));

    for (int n = 0; n < 200; n++) begin
      rd_din = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step($urandom_range(0, 3) != 0, 9'($urandom), 6'($urandom), rd_din,
           1'($urandom_range(0, 1)), $urandom_range(0, N_CH-1), $urandom_range(0, DEPTH-1));
    end
    read_all();

    single_op(0, 1, 3'b001, W'(0));
    repeat (NORM_TH) single_op(0, 1, 3'b010, W'($urandom));
    rd_en = 1'b1; rd_ch = 2'd0; rd_addr = AW'(1);
    @(negedge clk);
    rd_en = 1'b0;
    check_val("norm2_ready", RW'(in_ready), RW'(0));
    rstn = 1'b0;
    #1;
    check_val("abort_ready", RW'(in_ready), RW'(1));
    check_val("abort_rd_valid", RW'(rd_valid), RW'(0));
    check_val("abort_rd_data", rd_data, '0);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    @(negedge clk);
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
